ff_mem_arb: RTL and testbench

Arbiter and sequencer for the single board SRAM shared between the 68000 bus interface and the video fetch engine inside `ff`. It grants one requester at a time and runs a fixed-length SRAM access with registered control strobes. It returns read data with a one-cycle acknowledge pulse. It sits between those two masters and the top-level SRAM pins, in the `clk_12mhz` domain.

---
 rtl/ff_mem_pkg.sv | 27 ++
 rtl/ff_mem_pick.sv | 27 ++
 rtl/ff_mem_arb.sv | 183 ++++++++++++++++++
 tb/tb_ff_mem_arb.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ff_mem_pkg.sv
// Shared types and constants for the board SRAM arbiter.
package ff_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    typedef enum logic {
        GNT_VID = 1'b0,
        GNT_CPU = 1'b1
    } gnt_t;

    localparam int unsigned AW_DEF      = 18;
    localparam int unsigned DW_DEF      = 16;
    localparam int unsigned ACC_CYC_DEF = 2;

    // Strobe bundle order: {ce_n, oe_n, we_n, ub_n, lb_n, dq_oe}
    localparam logic [5:0] STROBES_OFF = 6'b111110;

    // Active strobe pattern for one access of the given direction and lanes.
    function automatic logic [5:0] sram_strobes(input logic we, input logic [1:0] be);
        return {1'b0, we, ~we, ~be[1], ~be[0], we};
    endfunction

endpackage

// File: rtl/ff_mem_pick.sv
// Two-way round-robin winner select between video and CPU requests.
module ff_mem_pick
    import ff_mem_pkg::*;
(
    input  gnt_t last,
    input  logic vid_req,
    input  logic cpu_req,
    output logic any,
    output gnt_t win
);

    // On a tie the requester not served last time wins.
    always_comb begin
        any = vid_req | cpu_req;
        win = GNT_VID;
        if (vid_req && cpu_req) begin
            if (last == GNT_CPU) begin
                win = GNT_VID;
            end else begin
                win = GNT_CPU;
            end
        end else if (cpu_req) begin
            win = GNT_CPU;
        end
    end

endmodule

// File: rtl/ff_mem_arb.sv
// Board SRAM arbiter/sequencer: grants video or CPU, runs a fixed-length access
// with registered strobes and returns a one-cycle ack with captured read data.
module ff_mem_arb
    import ff_mem_pkg::*;
#(
    parameter int unsigned AW      = AW_DEF,
    parameter int unsigned DW      = DW_DEF,
    parameter int unsigned ACC_CYC = ACC_CYC_DEF
) (
    input  logic          clk_12mhz,
    input  logic          reset,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic          vid_ack,
    output logic [DW-1:0] vid_rdata,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [1:0]    cpu_be,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    output logic [AW-1:0] sram_addr,
    output logic [DW-1:0] sram_dq_o,
    output logic          sram_dq_oe,
    input  logic [DW-1:0] sram_dq_i,
    output logic          sram_ce_n,
    output logic          sram_oe_n,
    output logic          sram_we_n,
    output logic          sram_ub_n,
    output logic          sram_lb_n,
    output logic          busy
);

    localparam int unsigned CW = (ACC_CYC > 1) ? $clog2(ACC_CYC) : 1;

    state_t          state_q, state_d;
    gnt_t            gnt_q, gnt_d;
    gnt_t            last_q, last_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            we_q, we_d;
    logic [1:0]      be_q, be_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   dqo_q, dqo_d;
    logic [5:0]      strb_q, strb_d;
    logic            vid_ack_q, vid_ack_d;
    logic            cpu_ack_q, cpu_ack_d;
    logic [DW-1:0]   vid_rdata_q, vid_rdata_d;
    logic [DW-1:0]   cpu_rdata_q, cpu_rdata_d;
    logic            busy_q, busy_d;

    logic            any_req;
    gnt_t            win;

    ff_mem_pick u_pick (
        .last    (last_q),
        .vid_req (vid_req),
        .cpu_req (cpu_req),
        .any     (any_req),
        .win     (win)
    );

    // Next-state, latched transaction fields and registered output values.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        be_d        = be_q;
        addr_d      = addr_q;
        dqo_d       = dqo_q;
        strb_d      = STROBES_OFF;
        vid_ack_d   = 1'b0;
        cpu_ack_d   = 1'b0;
        vid_rdata_d = vid_rdata_q;
        cpu_rdata_d = cpu_rdata_q;

        unique case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    gnt_d = win;
                    cnt_d = CW'(ACC_CYC - 1);
                    if (win == GNT_CPU) begin
                        we_d   = cpu_we;
                        be_d   = cpu_be;
                        addr_d = cpu_addr;
                        if (cpu_we) begin
                            dqo_d = cpu_wdata;
                        end
                    end else begin
                        we_d   = 1'b0;
                        be_d   = 2'b11;
                        addr_d = vid_addr;
                    end
                    // Strobes registered here so they are live in the first ACCESS cycle.
                    strb_d  = sram_strobes(we_d, be_d);
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (cnt_q == '0) begin
                    if (!we_q) begin
                        if (gnt_q == GNT_CPU) begin
                            cpu_rdata_d = sram_dq_i;
                        end else begin
                            vid_rdata_d = sram_dq_i;
                        end
                    end
                    if (gnt_q == GNT_CPU) begin
                        cpu_ack_d = 1'b1;
                    end else begin
                        vid_ack_d = 1'b1;
                    end
                    state_d = ST_DONE;
                end else begin
                    cnt_d  = cnt_q - CW'(1);
                    strb_d = sram_strobes(we_q, be_q);
                end
            end
            ST_DONE: begin
                // Requests are not sampled here; the ack'd master drops req this edge.
                last_d  = gnt_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State register with synchronous active-low reset; abandons any access.
    always_ff @(posedge clk_12mhz) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            gnt_q       <= GNT_VID;
            last_q      <= GNT_CPU;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            be_q        <= 2'b00;
            addr_q      <= '0;
            dqo_q       <= '0;
            strb_q      <= STROBES_OFF;
            vid_ack_q   <= 1'b0;
            cpu_ack_q   <= 1'b0;
            vid_rdata_q <= '0;
            cpu_rdata_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            be_q        <= be_d;
            addr_q      <= addr_d;
            dqo_q       <= dqo_d;
            strb_q      <= strb_d;
            vid_ack_q   <= vid_ack_d;
            cpu_ack_q   <= cpu_ack_d;
            vid_rdata_q <= vid_rdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            busy_q      <= busy_d;
        end
    end

    assign sram_ce_n  = strb_q[5];
    assign sram_oe_n  = strb_q[4];
    assign sram_we_n  = strb_q[3];
    assign sram_ub_n  = strb_q[2];
    assign sram_lb_n  = strb_q[1];
    assign sram_dq_oe = strb_q[0];
    assign sram_addr  = addr_q;
    assign sram_dq_o  = dqo_q;
    assign vid_ack    = vid_ack_q;
    assign cpu_ack    = cpu_ack_q;
    assign vid_rdata  = vid_rdata_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_ff_mem_arb.sv
// Self-checking bench for ff_mem_arb: directed scenarios then random transactions
// checked against a transaction-level memory and round-robin model.
module tb_ff_mem_arb;

    localparam int unsigned AW = 18;
    localparam int unsigned DW = 16;

    logic          clk_12mhz = 1'b0;
    logic          reset;
    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic          vid_ack;
    logic [DW-1:0] vid_rdata;
    logic          cpu_req;
    logic          cpu_we;
    logic [1:0]    cpu_be;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ack;
    logic [DW-1:0] cpu_rdata;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_dq_o;
    logic          sram_dq_oe;
    logic [DW-1:0] sram_dq_i;
    logic          sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;
    logic          busy;

    int nchk  = 0;
    int nfail = 0;

    // 1 = CPU was served last; tie-break model for the round-robin.
    bit last_cpu = 1'b1;

    logic [15:0] sram_mem [0:1023];
    logic [15:0] ref_mem  [0:1023];
    bit          inited = 1'b0;

    ff_mem_arb #(.AW(AW), .DW(DW), .ACC_CYC(2)) dut (
        .clk_12mhz  (clk_12mhz),
        .reset      (reset),
        .vid_req    (vid_req),
        .vid_addr   (vid_addr),
        .vid_ack    (vid_ack),
        .vid_rdata  (vid_rdata),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_be     (cpu_be),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_ack    (cpu_ack),
        .cpu_rdata  (cpu_rdata),
        .sram_addr  (sram_addr),
        .sram_dq_o  (sram_dq_o),
        .sram_dq_oe (sram_dq_oe),
        .sram_dq_i  (sram_dq_i),
        .sram_ce_n  (sram_ce_n),
        .sram_oe_n  (sram_oe_n),
        .sram_we_n  (sram_we_n),
        .sram_ub_n  (sram_ub_n),
        .sram_lb_n  (sram_lb_n),
        .busy       (busy)
    );

    always #5 clk_12mhz = ~clk_12mhz;

    function automatic logic [15:0] init_val(input int i);
        if (i == 32'h234) return 16'hBEEF;
        return 16'(i * 7) ^ 16'h5A5A;
    endfunction

    // SRAM device model: byte-lane writes at the clock edge.
    always @(posedge clk_12mhz) begin
        if (!inited) begin
            for (int i = 0; i < 1024; i++) sram_mem[i] <= init_val(i);
            inited <= 1'b1;
        end else if (!sram_ce_n && !sram_we_n) begin
            if (!sram_ub_n) sram_mem[sram_addr[9:0]][15:8] <= sram_dq_o[15:8];
            if (!sram_lb_n) sram_mem[sram_addr[9:0]][7:0]  <= sram_dq_o[7:0];
        end
    end

    // SRAM read data, settled mid-cycle; garbage when not output-enabled.
    always @(negedge clk_12mhz) begin
        sram_dq_i <= (!sram_ce_n && !sram_oe_n) ? sram_mem[sram_addr[9:0]] : 16'hDEAD;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] exp_strobes(input logic we, input logic [1:0] be);
        // {ce_n, oe_n, we_n, ub_n, lb_n, dq_oe}
        return {1'b0, we, !we, !be[1], !be[0], we};
    endfunction

    function automatic logic [5:0] obs_strobes();
        return {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, sram_dq_oe};
    endfunction

    // One arbitration round: video and/or CPU request raised together, each dropped on its ack.
    task automatic xact(input bit dov, input bit doc, input logic cwe, input logic [1:0] cbe,
                        input logic [AW-1:0] caddr, input logic [15:0] cwdata,
                        input logic [AW-1:0] vaddr);
        bit first_cpu;
        bit vdone;
        bit cdone;
        first_cpu = doc && (!dov || !last_cpu);
        vdone = 1'b0;
        cdone = 1'b0;
        @(negedge clk_12mhz);
        vid_req   = dov;
        vid_addr  = vaddr;
        cpu_req   = doc;
        cpu_we    = cwe;
        cpu_be    = cbe;
        cpu_addr  = caddr;
        cpu_wdata = cwdata;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            int   slot;
            bit   serv_cpu;
            bit   act;
            bit   strobing;
            logic [5:0] es;
            @(negedge clk_12mhz);
            slot     = (cyc <= 3) ? 0 : 1;
            serv_cpu = (slot == 0) ? first_cpu : !first_cpu;
            act      = (slot == 0) || (dov && doc && cyc <= 7);
            strobing = act && (cyc % 4 == 1 || cyc % 4 == 2);
            es = strobing ? exp_strobes(serv_cpu ? cwe : 1'b0, serv_cpu ? cbe : 2'b11)
                          : 6'b111110;
            chk("strobes", 32'(obs_strobes()), 32'(es));
            if (strobing) begin
                chk("sram_addr", 32'(sram_addr), 32'(serv_cpu ? caddr : vaddr));
                if (serv_cpu && cwe) chk("sram_dq_o", 32'(sram_dq_o), 32'(cwdata));
            end
            chk("busy", 32'(busy), 32'(act && (cyc % 4 != 0)));
            chk("vid_ack", 32'(vid_ack), 32'(act && cyc % 4 == 3 && !serv_cpu));
            chk("cpu_ack", 32'(cpu_ack), 32'(act && cyc % 4 == 3 && serv_cpu));
            if (act && cyc % 4 == 3 && !serv_cpu) begin
                vdone   = 1'b1;
                vid_req = 1'b0;
                chk("vid_rdata", 32'(vid_rdata), 32'(ref_mem[vaddr[9:0]]));
            end
            if (act && cyc % 4 == 3 && serv_cpu) begin
                cdone   = 1'b1;
                cpu_req = 1'b0;
                if (!cwe) begin
                    chk("cpu_rdata", 32'(cpu_rdata), 32'(ref_mem[caddr[9:0]]));
                end else begin
                    if (cbe[1]) ref_mem[caddr[9:0]][15:8] = cwdata[15:8];
                    if (cbe[0]) ref_mem[caddr[9:0]][7:0]  = cwdata[7:0];
                end
            end
            if ((vdone || !dov) && (cdone || !doc)) break;
        end
        chk("done_vid", 32'(vdone), 32'(dov));
        chk("done_cpu", 32'(cdone), 32'(doc));
        vid_req = 1'b0;
        cpu_req = 1'b0;
        if (doc) last_cpu = dov ? !first_cpu : 1'b1;
        else     last_cpu = 1'b0;
        @(negedge clk_12mhz);
        chk("idle_acks", 32'({vid_ack, cpu_ack, busy}), 32'(0));
        if (doc) chk("mem_cpu", 32'(sram_mem[caddr[9:0]]), 32'(ref_mem[caddr[9:0]]));
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(i);
        reset = 1'b0; vid_req = 1'b0; vid_addr = '0; cpu_req = 1'b0;
        cpu_we = 1'b0; cpu_be = 2'b00; cpu_addr = '0; cpu_wdata = '0;

        // Reset state
        repeat (3) @(negedge clk_12mhz);
        chk("rst_strobes", 32'(obs_strobes()), 32'(6'b111110));
        chk("rst_addr", 32'(sram_addr), 32'(0));
        chk("rst_dq_o", 32'(sram_dq_o), 32'(0));
        chk("rst_acks", 32'({vid_ack, cpu_ack, busy}), 32'(0));
        chk("rst_rdata", 32'({vid_rdata, cpu_rdata}), 32'(0));
        reset = 1'b1;
        @(negedge clk_12mhz);

        // Both requesting continuously: V,C,V,C acks at cycles 3,7,11,15
        begin
            int nack;
            nack = 0;
            vid_req = 1'b1; vid_addr = 18'h00100;
            cpu_req = 1'b1; cpu_we = 1'b0; cpu_be = 2'b11; cpu_addr = 18'h00200;
            for (int cyc = 1; cyc <= 16; cyc++) begin
                @(negedge clk_12mhz);
                chk("rr_vid_ack", 32'(vid_ack), 32'(cyc == 3 || cyc == 11));
                chk("rr_cpu_ack", 32'(cpu_ack), 32'(cyc == 7 || cyc == 15));
                if (cyc == 3 || cyc == 11) begin
                    nack++;
                    chk("rr_vid_rdata", 32'(vid_rdata), 32'(ref_mem[10'h100]));
                end
                if (cyc == 7 || cyc == 15) begin
                    nack++;
                    chk("rr_cpu_rdata", 32'(cpu_rdata), 32'(ref_mem[10'h200]));
                end
                if (cyc == 15) begin
                    vid_req = 1'b0;
                    cpu_req = 1'b0;
                end
            end
            chk("rr_nack", 32'(nack), 32'(4));
            last_cpu = 1'b1;
        end

        // CPU read of 0x01234, SRAM holds 0xBEEF
        xact(1'b0, 1'b1, 1'b0, 2'b11, 18'h01234, 16'h0000, 18'h0);
        chk("cpu_rd_beef", 32'(cpu_rdata), 32'h0000BEEF);

        // CPU upper-byte write
        xact(1'b0, 1'b1, 1'b1, 2'b10, 18'h00010, 16'hA55A, 18'h0);
        chk("bytewr_upper", 32'(sram_mem[10'h010][15:8]), 32'hA5);
        chk("bytewr_lower", 32'(sram_mem[10'h010][7:0]), 32'(init_val(32'h10) & 16'h00FF));

        // Write with no lanes enabled: full access, memory untouched
        xact(1'b0, 1'b1, 1'b1, 2'b00, 18'h00020, 16'h1234, 18'h0);
        chk("be00_mem", 32'(sram_mem[10'h020]), 32'(init_val(32'h20)));

        // Video holds req one extra cycle after ack: a second access follows
        @(negedge clk_12mhz);
        vid_req = 1'b1; vid_addr = 18'h00055;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge clk_12mhz);
            chk("held_vid_ack", 32'(vid_ack), 32'(cyc == 3 || cyc == 7));
            chk("held_busy", 32'(busy), 32'(cyc == 1 || cyc == 2 || cyc == 3 ||
                                            cyc == 5 || cyc == 6 || cyc == 7));
            if (cyc == 5) vid_req = 1'b0;
        end
        last_cpu = 1'b0;

        // Reset asserted during the first ACCESS cycle
        @(negedge clk_12mhz);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_be = 2'b11; cpu_addr = 18'h00077;
        @(negedge clk_12mhz);
        chk("rstmid_active", 32'(sram_ce_n), 32'(0));
        reset = 1'b0;
        cpu_req = 1'b0;
        @(negedge clk_12mhz);
        reset = 1'b1;
        chk("rstmid_strobes", 32'(obs_strobes()), 32'(6'b111110));
        chk("rstmid_rdata", 32'({vid_rdata, cpu_rdata}), 32'(0));
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(negedge clk_12mhz);
            chk("rstmid_noack", 32'({vid_ack, cpu_ack, busy}), 32'(0));
        end
        last_cpu = 1'b1;

        // Random mix of single and contending transactions
        for (int n = 0; n < 40; n++) begin
            int          sel;
            logic        rwe;
            logic [1:0]  rbe;
            logic [17:0] ra;
            logic [17:0] va;
            logic [15:0] rd;
            sel = $urandom_range(0, 2);
            rwe = 1'($urandom);
            rbe = 2'($urandom);
            ra  = 18'(32'h300 + $urandom_range(0, 7));
            va  = 18'(32'h300 + $urandom_range(0, 7));
            rd  = 16'($urandom);
            xact(sel != 1, sel != 0, rwe, rbe, ra, rd, va);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
